johnson_phase_monitor: RTL and testbench

- Downstream consumer of the 4-stage twisted-ring (Johnson) counter.
- Samples the counter's parallel output and decodes it to a phase index and a one-hot phase strobe.
- Checks that each new code is the legal successor of the previous one, runs a lock/fault state machine, and counts completed rotations.
- Feeds phase-sequenced control logic that must not act on a corrupted ring.

---
 rtl/johnson_phase_monitor_pkg.sv | 17 +
 rtl/johnson_decode.sv | 38 +++
 rtl/johnson_phase_monitor.sv | 165 ++++++++++++++++
 tb/tb_johnson_phase_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_phase_monitor_pkg.sv
// Shared definitions for consumers of a twisted-ring (Johnson) counter:
// lock/fault state encoding and the phase-index width helper.
package johnson_phase_monitor_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_FAULT    = 2'd3
  } state_e;

  // A WIDTH-stage ring has 2*WIDTH phases; this is the index width.
  function automatic int phase_width(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational decoder: maps a Johnson counter code to its phase index and
// flags codes that are not one of the 2*WIDTH legal ring states.
module johnson_decode
  import johnson_phase_monitor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]              q_in,
  output logic                          legal,
  output logic [phase_width(WIDTH)-1:0] phase_idx
);

  localparam int PW = phase_width(WIDTH);

  // Phases 0..WIDTH fill with ones from the LSB; later phases drain them
  // from the LSB again.
  function automatic logic [WIDTH-1:0] code_of(input int k);
    logic [WIDTH-1:0] ones;
    ones = '1;
    if (k <= WIDTH) return ones >> (WIDTH - k);
    return ones << (k - WIDTH);
  endfunction

  // Search all legal codes; at most one can match.
  // NOTE: every output gets a default first so no path through the block
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    legal     = 1'b0;
    phase_idx = '0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      if (q_in == code_of(k)) begin
        legal     = 1'b1;
        phase_idx = PW'(k);
      end
    end
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Samples a Johnson counter, decodes its phase, verifies each sample is the
// legal successor (or a hold) of the previous phase, tracks lock/fault status
// and counts completed rotations while locked.
module johnson_phase_monitor
  import johnson_phase_monitor_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int CYC_W      = 8
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic [WIDTH-1:0]              q_in,
  input  logic                          in_valid,
  input  logic                          clear_err,
  output logic [phase_width(WIDTH)-1:0] phase,
  output logic [2*WIDTH-1:0]            phase_onehot,
  output logic                          phase_valid,
  output logic                          locked,
  output logic                          err_pulse,
  output logic                          err,
  output logic                          wrap,
  output logic [CYC_W-1:0]              cyc_cnt
);

  localparam int NPH   = 2 * WIDTH;
  localparam int PW    = phase_width(WIDTH);
  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  localparam logic [PW-1:0]    LAST_PHASE = PW'(NPH - 1);
  localparam logic [RUN_W-1:0] RUN_LAST   = RUN_W'(LOCK_COUNT - 1);
  localparam logic [NPH-1:0]   ONEHOT_LSB = NPH'(1);

  state_e           r_state,       w_state_nxt;
  logic [PW-1:0]    r_phase,       w_phase_nxt;
  logic             r_phase_valid, w_phase_valid_nxt;
  logic [RUN_W-1:0] r_run,         w_run_nxt;
  logic             r_err,         w_err_nxt;
  logic             r_err_pulse,   w_err_pulse_nxt;
  logic             r_wrap,        w_wrap_nxt;
  logic [CYC_W-1:0] r_cyc_cnt,     w_cyc_cnt_nxt;

  logic             w_legal;
  logic [PW-1:0]    w_dec_phase;
  logic [PW-1:0]    w_succ_phase;
  logic             w_succ;
  logic             w_hold;

  johnson_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .q_in      (q_in),
    .legal     (w_legal),
    .phase_idx (w_dec_phase)
  );

  // Step classification relative to the last accepted phase; the ring may
  // have a non power-of-two phase count, so the successor wraps explicitly.
  assign w_succ_phase = (r_phase == LAST_PHASE) ? '0 : r_phase + PW'(1);
  assign w_succ       = w_legal && (w_dec_phase == w_succ_phase);
  assign w_hold       = w_legal && (w_dec_phase == r_phase);

  // Next-state and next-output logic for the lock/fault state machine.
  always_comb begin
    w_state_nxt       = r_state;
    w_phase_nxt       = r_phase;
    w_phase_valid_nxt = r_phase_valid;
    w_run_nxt         = r_run;
    w_err_nxt         = r_err;
    w_err_pulse_nxt   = 1'b0;
    w_wrap_nxt        = 1'b0;
    w_cyc_cnt_nxt     = r_cyc_cnt;

    // A sticky-error set below overrides this clear.
    if (clear_err) w_err_nxt = 1'b0;

    unique case (r_state)
      ST_UNLOCKED: begin
        if (in_valid) begin
          if (w_legal) begin
            w_state_nxt       = ST_ACQUIRE;
            w_phase_nxt       = w_dec_phase;
            w_run_nxt         = '0;
            w_phase_valid_nxt = 1'b1;
          end else begin
            w_err_pulse_nxt = 1'b1;
          end
        end
      end
      ST_ACQUIRE: begin
        if (in_valid) begin
          if (w_succ) begin
            w_phase_nxt = w_dec_phase;
            w_run_nxt   = r_run + RUN_W'(1);
            if (r_run == RUN_LAST) w_state_nxt = ST_LOCKED;
          end else if (!w_hold) begin
            w_state_nxt       = ST_UNLOCKED;
            w_run_nxt         = '0;
            w_phase_valid_nxt = 1'b0;
            w_err_pulse_nxt   = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (in_valid) begin
          if (w_succ) begin
            w_phase_nxt = w_dec_phase;
            if (r_phase == LAST_PHASE) begin
              w_wrap_nxt = 1'b1;
              if (r_cyc_cnt != '1) w_cyc_cnt_nxt = r_cyc_cnt + CYC_W'(1);
            end
          end else if (!w_hold) begin
            w_state_nxt     = ST_FAULT;
            w_err_pulse_nxt = 1'b1;
            w_err_nxt       = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        // Samples are ignored here; only clear_err leaves the fault.
        if (clear_err) begin
          w_state_nxt       = ST_UNLOCKED;
          w_run_nxt         = '0;
          w_phase_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_UNLOCKED;
    endcase
  end

  // State and output registers, cleared asynchronously by clr.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state       <= ST_UNLOCKED;
      r_phase       <= '0;
      r_phase_valid <= 1'b0;
      r_run         <= '0;
      r_err         <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_wrap        <= 1'b0;
      r_cyc_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_phase_valid <= w_phase_valid_nxt;
      r_run         <= w_run_nxt;
      r_err         <= w_err_nxt;
      r_err_pulse   <= w_err_pulse_nxt;
      r_wrap        <= w_wrap_nxt;
      r_cyc_cnt     <= w_cyc_cnt_nxt;
    end
  end

  assign phase        = r_phase;
  assign phase_onehot = r_phase_valid ? (ONEHOT_LSB << r_phase) : '0;
  assign phase_valid  = r_phase_valid;
  assign locked       = (r_state == ST_LOCKED);
  assign err_pulse    = r_err_pulse;
  assign err          = r_err;
  assign wrap         = r_wrap;
  assign cyc_cnt      = r_cyc_cnt;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Self-checking bench: directed scenarios plus randomized ring traffic,
// compared every cycle against a behavioural model of the monitor.
module tb_johnson_phase_monitor;

  localparam int LOCK_COUNT = 3;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] q_in;
  logic       in_valid;
  logic       clear_err;

  logic [2:0] phase,   s_phase;
  logic [7:0] phase_onehot, s_phase_onehot;
  logic       phase_valid, locked, err_pulse, err, wrap;
  logic       s_phase_valid, s_locked, s_err_pulse, s_err, s_wrap;
  logic [7:0] cyc_cnt;
  logic [1:0] s_cyc_cnt;

  always #5 clk = ~clk;

  johnson_phase_monitor #(.WIDTH(4), .LOCK_COUNT(LOCK_COUNT), .CYC_W(8)) dut (
    .clk(clk), .clr(clr), .q_in(q_in), .in_valid(in_valid), .clear_err(clear_err),
    .phase(phase), .phase_onehot(phase_onehot), .phase_valid(phase_valid),
    .locked(locked), .err_pulse(err_pulse), .err(err), .wrap(wrap), .cyc_cnt(cyc_cnt)
  );

  // Narrow rotation counter instance to exercise saturation.
  johnson_phase_monitor #(.WIDTH(4), .LOCK_COUNT(LOCK_COUNT), .CYC_W(2)) dut_sat (
    .clk(clk), .clr(clr), .q_in(q_in), .in_valid(in_valid), .clear_err(clear_err),
    .phase(s_phase), .phase_onehot(s_phase_onehot), .phase_valid(s_phase_valid),
    .locked(s_locked), .err_pulse(s_err_pulse), .err(s_err), .wrap(s_wrap),
    .cyc_cnt(s_cyc_cnt)
  );

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Legal ring codes in phase order, straight from the code table.
  logic [3:0] ring [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                           4'b1111, 4'b1110, 4'b1100, 4'b1000};

  localparam int M_UNLOCKED = 0, M_ACQUIRE = 1, M_LOCKED = 2, M_FAULT = 3;

  int m_mode, m_phase, m_pv, m_run, m_err, m_errp, m_wrap, m_cyc8, m_cyc2;

  function automatic int code_to_phase(input logic [3:0] c);
    for (int k = 0; k < 8; k++) if (ring[k] == c) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = M_UNLOCKED; m_phase = 0; m_pv = 0; m_run = 0;
    m_err = 0; m_errp = 0; m_wrap = 0; m_cyc8 = 0; m_cyc2 = 0;
  endtask

  task automatic model_step(input logic [3:0] code, input logic v, input logic ce);
    int  idx;
    bit  succ, hold;
    idx  = code_to_phase(code);
    succ = (idx >= 0) && (idx == (m_phase + 1) % 8);
    hold = (idx >= 0) && (idx == m_phase);
    m_errp = 0;
    m_wrap = 0;
    if (m_mode == M_FAULT) begin
      if (ce) begin
        m_mode = M_UNLOCKED; m_err = 0; m_pv = 0; m_run = 0;
      end
      return;
    end
    if (ce) m_err = 0;
    if (!v) return;
    case (m_mode)
      M_UNLOCKED:
        if (idx >= 0) begin
          m_mode = M_ACQUIRE; m_phase = idx; m_run = 0; m_pv = 1;
        end else m_errp = 1;
      M_ACQUIRE:
        if (succ) begin
          m_phase = idx;
          m_run++;
          if (m_run == LOCK_COUNT) m_mode = M_LOCKED;
        end else if (!hold) begin
          m_mode = M_UNLOCKED; m_run = 0; m_pv = 0; m_errp = 1;
        end
      M_LOCKED:
        if (succ) begin
          if (m_phase == 7) begin
            m_wrap = 1;
            if (m_cyc8 < 255) m_cyc8++;
            if (m_cyc2 < 3)   m_cyc2++;
          end
          m_phase = idx;
        end else if (!hold) begin
          m_mode = M_FAULT; m_errp = 1; m_err = 1;
        end
      default: ;
    endcase
  endtask

  task automatic compare_all(input string pfx);
    check({pfx, ".phase"},   32'(phase),        32'(m_phase));
    check({pfx, ".onehot"},  32'(phase_onehot), m_pv ? (32'd1 << m_phase) : 32'd0);
    check({pfx, ".pvalid"},  32'(phase_valid),  32'(m_pv));
    check({pfx, ".locked"},  32'(locked),       32'(m_mode == M_LOCKED));
    check({pfx, ".errp"},    32'(err_pulse),    32'(m_errp));
    check({pfx, ".err"},     32'(err),          32'(m_err));
    check({pfx, ".wrap"},    32'(wrap),         32'(m_wrap));
    check({pfx, ".cyc"},     32'(cyc_cnt),      32'(m_cyc8));
    check({pfx, ".s_cyc"},   32'(s_cyc_cnt),    32'(m_cyc2));
    check({pfx, ".s_locked"},32'(s_locked),     32'(m_mode == M_LOCKED));
  endtask

  // One sample cycle: drive, clock, update model, then check 1 time unit later.
  task automatic step(input string pfx, input logic [3:0] code, input logic v, input logic ce);
    q_in = code; in_valid = v; clear_err = ce;
    @(posedge clk);
    model_step(code, v, ce);
    #1;
    compare_all(pfx);
  endtask

  // Assert clr between clock edges and check the immediate clear.
  task automatic do_reset(input string pfx);
    #2;
    clr = 1'b0;
    model_reset();
    #1;
    compare_all(pfx);
    in_valid = 1'b0; clear_err = 1'b0;
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic feed(input string pfx, input int first, input int count);
    for (int i = 0; i < count; i++) step(pfx, ring[(first + i) % 8], 1'b1, 1'b0);
  endtask

  initial begin
    int pos;
    int r;
    logic ce;
    clr = 1'b0; q_in = '0; in_valid = 1'b0; clear_err = 1'b0;
    model_reset();
    #1;
    compare_all("reset");
    @(negedge clk);
    clr = 1'b1;

    // 1: lock acquisition
    feed("t1", 0, 4);
    check("t1.locked", 32'(locked), 32'd1);
    check("t1.phase", 32'(phase), 32'd3);
    check("t1.onehot", 32'(phase_onehot), 32'h08);

    // 2: wrap after 1000 -> 0000, then four more rotations for saturation
    feed("t2", 4, 5);
    check("t2.wrap", 32'(wrap), 32'd1);
    check("t2.cyc1", 32'(cyc_cnt), 32'd1);
    step("t2.hold", ring[0], 1'b1, 1'b0);
    check("t2.wrap_once", 32'(wrap), 32'd0);
    feed("t2.rot", 1, 32);
    check("t2.cyc5", 32'(cyc_cnt), 32'd5);
    check("t2.sat", 32'(s_cyc_cnt), 32'd3);
    check("t2.locked", 32'(locked), 32'd1);

    // 6: asynchronous reset while locked with cyc_cnt=5
    do_reset("t6");
    check("t6.cyc", 32'(cyc_cnt), 32'd0);
    check("t6.locked", 32'(locked), 32'd0);

    // 3: fault at phase 2 and clear
    feed("t3.lock", 6, 5);
    check("t3.ph2", 32'(phase), 32'd2);
    step("t3.bad", 4'b0101, 1'b1, 1'b0);
    check("t3.errp", 32'(err_pulse), 32'd1);
    check("t3.err", 32'(err), 32'd1);
    check("t3.phold", 32'(phase), 32'd2);
    step("t3.ignored", 4'b0111, 1'b1, 1'b0);
    check("t3.errp_once", 32'(err_pulse), 32'd0);
    step("t3.clear", 4'b0000, 1'b0, 1'b1);
    check("t3.err_clr", 32'(err), 32'd0);
    check("t3.pv_clr", 32'(phase_valid), 32'd0);
    feed("t3.relock", 0, 4);
    check("t3.relocked", 32'(locked), 32'd1);

    // 4: hold tolerance at 1000 then wrap
    feed("t4.adv", 4, 4);
    for (int i = 0; i < 5; i++) step("t4.hold", ring[7], 1'b1, 1'b0);
    step("t4.wrap", ring[0], 1'b1, 1'b0);
    check("t4.wrap1", 32'(wrap), 32'd1);
    check("t4.locked", 32'(locked), 32'd1);

    // simultaneous clear_err with a locked BAD sample, then clear in FAULT with a sample
    step("sim.bad", 4'b1010, 1'b1, 1'b1);
    check("sim.err_set_wins", 32'(err), 32'd1);
    step("sim.clr", ring[1], 1'b1, 1'b1);
    check("sim.discard", 32'(phase_valid), 32'd0);

    // 5: acquire skip from reset
    do_reset("t5.rst");
    step("t5", ring[0], 1'b1, 1'b0);
    step("t5", ring[1], 1'b1, 1'b0);
    step("t5.skip", ring[3], 1'b1, 1'b0);
    check("t5.errp", 32'(err_pulse), 32'd1);
    check("t5.pv", 32'(phase_valid), 32'd0);
    check("t5.err", 32'(err), 32'd0);

    // randomized ring traffic with occasional glitches, jumps and clears
    pos = 0;
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(0, 99));
      ce = ($urandom_range(0, 49) == 0);
      if (r < 70) begin
        pos = (pos + 1) % 8;
        step("rnd.succ", ring[pos], 1'b1, ce);
      end else if (r < 80) begin
        step("rnd.hold", ring[pos], 1'b1, ce);
      end else if (r < 88) begin
        step("rnd.idle", 4'($urandom_range(0, 15)), 1'b0, ce);
      end else if (r < 95) begin
        step("rnd.glitch", 4'($urandom_range(0, 15)), 1'b1, ce);
      end else begin
        pos = int'($urandom_range(0, 7));
        step("rnd.jump", ring[pos], 1'b1, ce);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
